// File: rtl/pixel_frame_writer.sv
// rtl/pixel_frame_writer.sv - frame capture into a FWFT FIFO with sof/eol/eof tagging
module pixel_frame_writer #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       pix_in,
  input  logic             pix_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [10:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              take, push, pop, sof, eol, eof;
  logic [10:0]       head;

  assign take = (state == CAPTURE) && pix_valid;
  // Full test uses the registered level, so a same-cycle pop cannot make room
  assign push = take && (level != LVL_FULL);
  assign pop  = (level != '0) && out_ready;
  assign sof  = (col == '0) && (row == '0);
  assign eol  = (col == COL_LAST);
  assign eof  = eol && (row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: if (take && eof) state_nxt = DRAIN;
      DRAIN:   if (level == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && (level == '0);
      if (state == IDLE && start) begin
        col      <= '0;
        row      <= '0;
        overflow <= 1'b0;
      end else if (take) begin
        // Dropped pixels still advance the position so geometry stays aligned
        if (!push) overflow <= 1'b1;
        if (eol) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pix_in, sof, eol, eof};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (level != '0);
  assign fifo_level = level;
  assign {out_data, out_sof, out_eol, out_eof} = out_valid ? head : 11'd0;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb/tb_pixel_frame_writer.sv - randomized bench against a queue-based frame/FIFO model
module tb_pixel_frame_writer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int DEPTH = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    pix_in = 8'd0;
  logic          pix_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_sof, out_eol, out_eof, out_valid;
  logic          busy, frame_done, overflow;
  logic [LW-1:0] fifo_level;

  pixel_frame_writer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0=idle 1=capture 2=drain; p = pixel index within frame
  int mode = 0;
  int p = 0;
  bit m_ovf = 0;
  bit m_fd = 0;
  int q[$];

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; p = 0; m_ovf = 0; m_fd = 0;
    q.delete();
  endtask

  task automatic check_outputs();
    int h;
    h = (q.size() != 0) ? q[0] : 0;
    check("out_valid", int'(out_valid), int'(q.size() != 0));
    check("out_data", int'(out_data), h >> 3);
    check("out_sof", int'(out_sof), (h >> 2) & 1);
    check("out_eol", int'(out_eol), (h >> 1) & 1);
    check("out_eof", int'(out_eof), h & 1);
    check("fifo_level", int'(fifo_level), q.size());
    check("busy", int'(busy), int'(mode != 0));
    check("frame_done", int'(frame_done), int'(m_fd));
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic model_step(input bit st, input bit pv, input int px, input bit rdy);
    int sz;
    bit pop, take, push_ok;
    int ent;
    sz = q.size();
    pop = (sz > 0) && rdy;
    take = (mode == 1) && pv;
    push_ok = take && (sz < DEPTH);
    m_fd = (mode == 2) && (sz == 0);
    ent = (px << 3) | (int'(p == 0) << 2) | (int'(p % W == W - 1) << 1) | int'(p == W * H - 1);
    if (take && !push_ok) m_ovf = 1;
    if (pop) void'(q.pop_front());
    if (push_ok) q.push_back(ent);
    case (mode)
      0: if (st) begin mode = 1; p = 0; m_ovf = 0; end
      1: if (take) begin p++; if (p == W * H) mode = 2; end
      2: if (sz == 0) mode = 0;
      default: mode = 0;
    endcase
  endtask

  task automatic cycle(input bit st, input bit pv, input int px, input bit rdy);
    @(negedge clk);
    check_outputs();
    start = st; pix_valid = pv; pix_in = px[7:0]; out_ready = rdy;
    @(posedge clk);
    if (rst_n) model_step(st, pv, px, rdy);
  endtask

  task automatic rcycle(input int pv_pct, input int rdy_pct, input int st_pct);
    cycle($urandom_range(99) < st_pct, $urandom_range(99) < pv_pct,
          int'($urandom_range(255)), $urandom_range(99) < rdy_pct);
  endtask

  initial begin
    model_reset();
    #3;
    check_outputs();
    rst_n = 1'b1;

    // Back-to-back frame, sink always ready
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 'h10 + i, 1);
    repeat (6) cycle(0, 0, 0, 1);

    // Stalled sink overflows the FIFO, then drains
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 'hA0 + i, 0);
    repeat (3) cycle(0, 0, 0, 0);
    repeat (8) cycle(0, 0, 0, 1);

    // Pixels in IDLE ignored; start while busy ignored
    repeat (4) cycle(0, 1, 'h55, 1);
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 'h30 + i, 1);
    repeat (6) cycle(0, 0, 0, 1);

    // Steady push+pop at level 2
    cycle(1, 0, 0, 0);
    cycle(0, 1, 'h60, 0);
    cycle(0, 1, 'h61, 0);
    for (int i = 2; i < 8; i++) cycle(0, 1, 'h60 + i, 1);
    repeat (6) cycle(0, 0, 0, 1);

    // Async reset mid-frame
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 'h70 + i, 0);
    #2;
    rst_n = 1'b0;
    start = 0; pix_valid = 0; out_ready = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 'h80 + i, 1);
    repeat (6) cycle(0, 0, 0, 1);

    // Randomized phases with varying pressure
    repeat (300) rcycle(70, 80, 10);
    repeat (300) rcycle(90, 30, 15);
    repeat (300) rcycle(40, 95, 20);
    repeat (300) rcycle(60, 60, 5);
    repeat (20) cycle(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
